// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU datapath and its command sequencer.
// Op codes 0-5 are single-pass ops, 6/7 are iterated 1-bit shifts, 8 re-reads the last result.
package alu_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 3;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOT  = 4'b0101;
    localparam logic [3:0] OP_SHL  = 4'b0110;
    localparam logic [3:0] OP_SHR  = 4'b0111;
    localparam logic [3:0] OP_LAST = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_sequencer.sv
// Command front-end for the ALU: registers operands/mode, iterates multi-bit shifts as
// single-bit ALU passes, and returns result/overflow on a valid/ready port.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_cin,
    input  logic             cmd_use_last,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_mode,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_overflow,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_overflow,
    output logic             res_err,
    output logic [WIDTH-1:0] last_result
);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]       mode_q, mode_d;
    logic             cin_q, cin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_ovf_q, res_ovf_d;
    logic             res_err_q, res_err_d;
    logic [WIDTH-1:0] last_q, last_d;

    logic             is_shift_q;
    logic             shl_ovf;
    logic [CNT_W-1:0] cmd_cnt;

    assign is_shift_q = (mode_q == OP_SHL) || (mode_q == OP_SHR);
    // Only SHL's shifted-out bit is meaningful; anything else from the ALU is don't-care.
    assign shl_ovf    = (mode_q == OP_SHL) && alu_overflow;
    assign cmd_cnt    = cmd_b[CNT_W-1:0];

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        mode_d     = mode_q;
        cin_d      = cin_q;
        cnt_d      = cnt_q;
        sticky_d   = sticky_q;
        res_data_d = res_data_q;
        res_ovf_d  = res_ovf_q;
        res_err_d  = res_err_q;
        last_d     = last_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    a_d       = cmd_use_last ? last_q : cmd_a;
                    b_d       = cmd_b;
                    mode_d    = cmd_op;
                    cin_d     = cmd_cin;
                    cnt_d     = cmd_cnt;
                    sticky_d  = 1'b0;
                    res_ovf_d = 1'b0;
                    res_err_d = 1'b0;
                    if (cmd_op <= OP_NOT) begin
                        state_d = ST_EXEC;
                    end else if (cmd_op == OP_SHL || cmd_op == OP_SHR) begin
                        if (cmd_cnt == '0) begin
                            res_data_d = a_d;
                            state_d    = ST_DONE;
                        end else begin
                            state_d = ST_EXEC;
                        end
                    end else if (cmd_op == OP_LAST) begin
                        res_data_d = last_q;
                        state_d    = ST_DONE;
                    end else begin
                        res_data_d = '0;
                        res_err_d  = 1'b1;
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_EXEC: begin
                if (is_shift_q) begin
                    // Feed the shifted value back so the next pass shifts it again.
                    a_d      = alu_out;
                    sticky_d = sticky_q | shl_ovf;
                    if (cnt_q == CNT_W'(1)) begin
                        res_data_d = alu_out;
                        res_ovf_d  = sticky_q | shl_ovf;
                        state_d    = ST_DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end else begin
                    res_data_d = alu_out;
                    res_ovf_d  = (mode_q == OP_ADD) && alu_overflow;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    if (!res_err_q) last_d = res_data_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            mode_q     <= '0;
            cin_q      <= 1'b0;
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
            res_data_q <= '0;
            res_ovf_q  <= 1'b0;
            res_err_q  <= 1'b0;
            last_q     <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            mode_q     <= mode_d;
            cin_q      <= cin_d;
            cnt_q      <= cnt_d;
            sticky_q   <= sticky_d;
            res_data_q <= res_data_d;
            res_ovf_q  <= res_ovf_d;
            res_err_q  <= res_err_d;
            last_q     <= last_d;
        end
    end

    assign cmd_ready    = (state_q == ST_IDLE);
    assign res_valid    = (state_q == ST_DONE);
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_mode     = mode_q;
    assign alu_cin      = cin_q;
    assign res_data     = res_data_q;
    assign res_overflow = res_ovf_q;
    assign res_err      = res_err_q;
    assign last_result  = last_q;

endmodule
